calc_loader: RTL and testbench
==============================

CALC_LOADER -- requirements
Module: calc_loader

Interface
REQ-001 Parameter ADDR_W, default 9, SRAM word address width (512 entries).
REQ-002 Parameter DATA_W, default 32, input operand width.
REQ-003 Parameter MEM_WORD_SIZE, default 64, packed SRAM word width {op_b, op_a}; SHALL equal 2*DATA_W.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  one-cycle load request; sampled only in IDLE.
REQ-007 load_start_addr_i  input  ADDR_W  first SRAM address to fill.
REQ-008 load_end_addr_i  input  ADDR_W  last SRAM address to fill, inclusive.
REQ-009 abort_i  input  1  cancel an in-progress load.
REQ-010 in_valid_i  input  1  upstream operand valid.
REQ-011 in_data_i  input  DATA_W  upstream operand.
REQ-012 in_ready_o  output  1  operand accepted when in_valid_i && in_ready_o.
REQ-013 mem_write_o  output  1  active-high SRAM write strobe; top level inverts for csb0/web0.
REQ-014 mem_addr_o  output  ADDR_W  SRAM port-0 address.
REQ-015 mem_data_o  output  MEM_WORD_SIZE  SRAM port-0 write data; bits [31:0] to lower macro, [63:32] to upper macro.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse on successful completion; usable as the calculator controller start.
REQ-018 err_o  output  1  one-cycle pulse on rejected start.
REQ-019 words_written_o  output  ADDR_W+1  count of SRAM words written by the current/last load.

Function
REQ-020 FSM states SHALL be IDLE, PACK_LO, PACK_HI, WRITE, DONE.
REQ-021 IDLE: in_ready_o=0; start_i with load_end_addr_i >= load_start_addr_i -> latch both addresses, clear words_written_o and the data register, go PACK_LO.
REQ-022 IDLE: start_i with load_end_addr_i < load_start_addr_i -> err_o=1 next cycle, stay IDLE, no write.
REQ-023 PACK_LO: in_ready_o=1; on handshake capture in_data_i into mem_data_o[31:0], go PACK_HI.
REQ-024 PACK_HI: in_ready_o=1; on handshake capture in_data_i into mem_data_o[63:32], go WRITE.
REQ-025 No handshake in PACK_LO/PACK_HI -> hold state and data indefinitely.
REQ-026 WRITE: exactly one cycle, mem_write_o=1, in_ready_o=0, mem_addr_o=current address; words_written_o increments at the end of the cycle.
REQ-027 WRITE with current address == latched end address -> DONE; otherwise address+1, go PACK_LO.
REQ-028 Address SHALL never wrap; the end-address compare terminates the load first, including end = 2^ADDR_W-1.
REQ-029 DONE: done_o=1 for exactly one cycle, then IDLE; the next start_i is accepted the cycle after DONE.
REQ-030 Load latency: word N is written 2 accepted operands plus 1 cycle after word N-1; with in_valid_i held high, K words take 3K+1 cycles from start_i to done_o.
REQ-031 abort_i in PACK_LO/PACK_HI/WRITE -> IDLE at next edge; a partially packed word is discarded; the write presented in an aborted WRITE cycle still completes; done_o stays low.
REQ-032 abort_i in IDLE or DONE has no effect; abort_i concurrent with start_i in IDLE: abort wins, no load.
REQ-033 start_i while busy_o=1 is ignored.
REQ-034 mem_write_o, in_ready_o, busy_o are decoded from state only (no combinational in_valid_i path).

Reset
REQ-035 rst_i low SHALL immediately force IDLE, in_ready_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, busy_o=0, done_o=0, err_o=0, words_written_o=0.
REQ-036 Reset mid-load SHALL discard all progress; no write occurs while rst_i is low or on the first edge after release.

Verification
REQ-037 start 0..1, in_valid held, data 1,2,3,4 -> writes addr0=0x00000002_00000001, addr1=0x00000004_00000003, done_o at cycle 7, words_written_o=2.
REQ-038 start 5..5 with in_valid toggling every other cycle -> single write at addr5, no premature write, done_o once.
REQ-039 start 9..3 -> err_o pulse, busy_o stays 0, no write.
REQ-040 start 0..3, abort after 3 operands -> exactly one write (addr0), no done_o, busy_o=0 next cycle.
REQ-041 start 510..511 (ADDR_W=9) -> writes 510 and 511 only, no wrap to 0.
REQ-042 rst_i asserted during PACK_HI -> all outputs reset asynchronously; next start 0..0 writes a freshly packed word.

Source files
------------

// File: rtl/calc_loader.sv
// Operand loader: packs pairs of DATA_W operands into MEM_WORD_SIZE words
// and writes them to an inclusive SRAM address range, one word per pair.
module calc_loader #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        load_start_addr_i,
  input  logic [ADDR_W-1:0]        load_end_addr_i,
  input  logic                     abort_i,
  input  logic                     in_valid_i,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     in_ready_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_W:0]          words_written_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PACK_LO = 3'd1,
    PACK_HI = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        end_addr_q;
  logic [MEM_WORD_SIZE-1:0] data_q;
  logic [ADDR_W:0]          words_q;
  logic                     in_ready_q;
  logic                     mem_write_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;
  logic                     start_req;
  logic                     range_ok;

  // abort_i has priority over a concurrent start
  assign start_req = start_i && !abort_i;
  assign range_ok  = (load_end_addr_i >= load_start_addr_i);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_req && range_ok) begin
          state_d = PACK_LO;
        end else begin
          state_d = IDLE;
        end
      end
      PACK_LO: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (in_valid_i) begin
          state_d = PACK_HI;
        end else begin
          state_d = PACK_LO;
        end
      end
      PACK_HI: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (in_valid_i) begin
          state_d = WRITE;
        end else begin
          state_d = PACK_HI;
        end
      end
      WRITE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (addr_q == end_addr_q) begin
          state_d = DONE;
        end else begin
          state_d = PACK_LO;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; strobes follow the next state only
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      end_addr_q  <= '0;
      data_q      <= '0;
      words_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == PACK_LO) || (state_d == PACK_HI);
      mem_write_q <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      err_q       <= (state_q == IDLE) && start_req && !range_ok;
      case (state_q)
        IDLE: begin
          if (state_d == PACK_LO) begin
            addr_q     <= load_start_addr_i;
            end_addr_q <= load_end_addr_i;
            words_q    <= '0;
            data_q     <= '0;
          end
        end
        PACK_LO: begin
          if (state_d == PACK_HI) begin
            data_q[DATA_W-1:0] <= in_data_i;
          end
        end
        PACK_HI: begin
          if (state_d == WRITE) begin
            data_q[MEM_WORD_SIZE-1:DATA_W] <= in_data_i;
          end
        end
        WRITE: begin
          // The strobe is already on the bus, so an aborted write still counts
          words_q <= words_q + (ADDR_W+1)'(1);
          if (state_d == PACK_LO) begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign mem_write_o     = mem_write_q;
  assign mem_addr_o      = addr_q;
  assign mem_data_o      = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign words_written_o = words_q;

endmodule

// File: tb/tb_calc_loader.sv
// Randomized bench for calc_loader: a transaction-level model predicts the
// written words from the operands the bench hands over.
module tb_calc_loader;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [8:0]  load_start_addr_i;
  logic [8:0]  load_end_addr_i;
  logic        abort_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic        mem_write_o;
  logic [8:0]  mem_addr_o;
  logic [63:0] mem_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [9:0]  words_written_o;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  logic [8:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          done_cyc_q[$];

  calc_loader #(.ADDR_W(9), .DATA_W(32), .MEM_WORD_SIZE(64)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .load_start_addr_i(load_start_addr_i),
    .load_end_addr_i  (load_end_addr_i),
    .abort_i          (abort_i),
    .in_valid_i       (in_valid_i),
    .in_data_i        (in_data_i),
    .in_ready_o       (in_ready_o),
    .mem_write_o      (mem_write_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .words_written_o  (words_written_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every write strobe, done and err pulse away from the clock edge
  always @(negedge clk_i) begin
    if (mem_write_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
    end
    if (done_o) done_cyc_q.push_back(cyc);
    if (err_o) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cyc_q.delete();
    err_cnt = 0;
  endtask

  function automatic logic [87:0] all_outputs();
    return {in_ready_o, mem_write_o, mem_addr_o, mem_data_o, busy_o, done_o, err_o, words_written_o};
  endfunction

  // One load: abort_at = number of accepted operands after which abort_i is pulsed (-1: none)
  task automatic run_load(input int s, input int e, input int vpct, input int abort_at, input bit seqd);
    logic [31:0] ops[$];
    logic [31:0] item;
    logic [8:0]  exp_addr;
    int k_words, accepted, guard, exp_w, c0;
    bit hs, aborted;
    k_words = e - s + 1;
    clear_log();
    start_i = 1'b1;
    load_start_addr_i = 9'(s);
    load_end_addr_i = 9'(e);
    c0 = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    accepted = 0;
    guard = 0;
    aborted = 1'b0;
    item = seqd ? 32'd1 : $urandom();
    while (!aborted && accepted < 2 * k_words && guard < 400) begin
      // A second start while busy must be ignored
      start_i = (guard == 0);
      load_start_addr_i = 9'(s + 1);
      load_end_addr_i = 9'd511;
      in_valid_i = ($urandom_range(99) < vpct);
      in_data_i = item;
      @(negedge clk_i);
      hs = in_valid_i && in_ready_o;
      @(posedge clk_i); #1;
      if (hs) begin
        ops.push_back(item);
        accepted++;
        item = seqd ? 32'(accepted + 1) : $urandom();
        if (abort_at >= 0 && accepted == abort_at) begin
          start_i = 1'b0;
          in_valid_i = 1'b0;
          abort_i = 1'b1;
          @(posedge clk_i); #1;
          abort_i = 1'b0;
          aborted = 1'b1;
        end
      end
      guard++;
    end
    start_i = 1'b0;
    in_valid_i = 1'b0;
    check("ops_accepted", accepted, aborted ? abort_at : 2 * k_words);
    if (aborted) begin
      @(negedge clk_i);
      check("busy_after_abort", busy_o, 1'b0);
    end
    repeat (6) @(posedge clk_i);
    #1;
    exp_w = aborted ? abort_at / 2 : k_words;
    check("write_count", wr_addr_q.size(), exp_w);
    for (int i = 0; i < exp_w && i < wr_addr_q.size(); i++) begin
      exp_addr = 9'(s + i);
      check("write_addr", wr_addr_q[i], exp_addr);
      check("write_data", wr_data_q[i], {ops[2*i+1], ops[2*i]});
    end
    check("done_count", done_cyc_q.size(), aborted ? 0 : 1);
    if (!aborted && vpct >= 100 && done_cyc_q.size() > 0)
      check("done_latency", done_cyc_q[0] - c0, 3 * k_words + 1);
    @(negedge clk_i);
    check("words_written", words_written_o, exp_w);
    check("busy_idle", busy_o, 1'b0);
    check("no_err", err_cnt, 0);
  endtask

  task automatic run_err(input int s, input int e);
    clear_log();
    start_i = 1'b1;
    load_start_addr_i = 9'(s);
    load_end_addr_i = 9'(e);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("err_pulse", err_o, 1'b1);
    check("err_busy", busy_o, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    check("err_no_write", wr_addr_q.size(), 0);
    check("err_once", err_cnt, 1);
    check("err_busy_after", busy_o, 1'b0);
  endtask

  initial begin
    int s, k, e, vpct, ab;
    rst_i = 1'b0;
    start_i = 1'b0;
    load_start_addr_i = 9'd0;
    load_end_addr_i = 9'd0;
    abort_i = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = 32'd0;
    #3;
    check("reset_outputs", all_outputs(), 88'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Two words, data 1..4, valid held
    run_load(0, 1, 100, -1, 1'b1);
    // Single word with sparse valid
    run_load(5, 5, 50, -1, 1'b0);
    run_err(9, 3);
    // Abort after three operands
    run_load(0, 3, 100, 3, 1'b0);
    // Top of the address space, no wrap
    run_load(510, 511, 100, -1, 1'b0);

    // Abort concurrent with start in IDLE: no load
    clear_log();
    start_i = 1'b1;
    abort_i = 1'b1;
    load_start_addr_i = 9'd2;
    load_end_addr_i = 9'd4;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk_i);
    check("abort_start_busy", busy_o, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_start_writes", wr_addr_q.size(), 0);

    // Reset while in PACK_HI of the second word
    clear_log();
    start_i = 1'b1;
    load_start_addr_i = 9'd0;
    load_end_addr_i = 9'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = 32'h11;
    @(posedge clk_i); #1;
    in_data_i = 32'h22;
    @(posedge clk_i); #1;
    in_data_i = 32'h33;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    check("reset_mid_load", all_outputs(), 88'd0);
    check("reset_prior_writes", wr_addr_q.size(), 1);
    if (wr_data_q.size() > 0) check("reset_prior_data", wr_data_q[0], 64'h00000022_00000011);
    @(posedge clk_i); #2 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_no_write", wr_addr_q.size(), 1);
    run_load(0, 0, 100, -1, 1'b0);

    // Randomized loads
    for (int t = 0; t < 12; t++) begin
      s = $urandom_range(511);
      k = $urandom_range(1, 4);
      e = (s + k - 1 > 511) ? 511 : s + k - 1;
      k = e - s + 1;
      vpct = ($urandom_range(3) == 0) ? 100 : $urandom_range(30, 90);
      ab = ($urandom_range(3) == 0 && k > 1) ? $urandom_range(1, 2 * k - 1) : -1;
      run_load(s, e, vpct, ab, 1'b0);
    end
    run_err(300, 299);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
